// File: rtl/usb_pkg.sv
// Shared USB definitions: PID encodings, transmit request codes, CRC16 constants
// and the default SYNC byte, used by both the transmit and receive control units.
package usb_pkg;

   typedef enum logic [3:0] {
      PID_NONE  = 4'b0000,
      PID_OUT   = 4'b0001,
      PID_IN    = 4'b1001,
      PID_DATA0 = 4'b0011,
      PID_DATA1 = 4'b1011,
      PID_ACK   = 4'b0010,
      PID_NAK   = 4'b1010,
      PID_STALL = 4'b1110
   } pidType;

   localparam logic [2:0] REQ_NONE  = 3'd0;
   localparam logic [2:0] REQ_DATA0 = 3'd1;
   localparam logic [2:0] REQ_DATA1 = 3'd2;
   localparam logic [2:0] REQ_ACK   = 3'd3;
   localparam logic [2:0] REQ_NAK   = 3'd4;
   localparam logic [2:0] REQ_STALL = 3'd5;

   // Polynomial x^16+x^15+x^2+1; the reflected form suits LSB-first bytes.
   localparam logic [15:0] CRC16_POLY      = 16'h8005;
   localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
   localparam logic [15:0] CRC16_SEED      = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUAL  = 16'h800D;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h80;

   function automatic pidType req_to_pid(input logic [2:0] code);
      case (code)
         REQ_DATA0: return PID_DATA0;
         REQ_DATA1: return PID_DATA1;
         REQ_ACK:   return PID_ACK;
         REQ_NAK:   return PID_NAK;
         REQ_STALL: return PID_STALL;
         default:   return PID_NONE;
      endcase
   endfunction

endpackage

// File: rtl/usb_tx_pcu_if.sv
// Bundle between the transmit packet control unit and its neighbours: protocol
// request, packet FIFO and the byte-wide serializer handshake.
interface usb_tx_pcu_if;

   logic [2:0] tx_packet;
   logic [6:0] buffer_occupancy;
   logic [7:0] tx_packet_data;
   logic       byte_sent;
   logic       eop_done;
   logic       get_tx_packet_data;
   logic       load_byte;
   logic [7:0] tx_byte;
   logic       send_eop;
   logic       tx_transfer_active;
   logic       tx_done;
   logic       tx_error;
   logic       flush;

   modport slave (
      input  tx_packet, buffer_occupancy, tx_packet_data, byte_sent, eop_done,
      output get_tx_packet_data, load_byte, tx_byte, send_eop,
             tx_transfer_active, tx_done, tx_error, flush
   );

   modport master (
      output tx_packet, buffer_occupancy, tx_packet_data, byte_sent, eop_done,
      input  get_tx_packet_data, load_byte, tx_byte, send_eop,
             tx_transfer_active, tx_done, tx_error, flush
   );

endinterface

// File: rtl/usb_crc16_byte.sv
// Combinational USB CRC16 update over one byte, bits consumed LSB first.
module usb_crc16_byte
   import usb_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data_byte,
   output logic [15:0] crc_out
);

   logic [15:0] crc;

   always_comb begin
      crc = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (crc[0] ^ data_byte[i]) crc = (crc >> 1) ^ CRC16_POLY_REFL;
         else                       crc = crc >> 1;
      end
      crc_out = crc;
   end

endmodule

// File: rtl/usb_tx_pcu.sv
// USB transmit packet control unit: SYNC, PID, FIFO payload, CRC16 and EOP
// sequencing over a load/done byte handshake. Optional USB_TX_TIMEOUT_EN adds a
// serializer watchdog that aborts a stalled packet.
module usb_tx_pcu
   import usb_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
   parameter int         MAX_DATA  = 64
`ifdef USB_TX_TIMEOUT_EN
   ,
   parameter int         TIMEOUT   = 1023
`endif
) (
   input  logic         clk,
   input  logic         n_rst,
   usb_tx_pcu_if.slave  bus
);

   typedef enum logic [3:0] {
      IDLE, SYNC_LD, SYNC_WT, PID_LD, PID_WT, DATA_LD, DATA_WT,
      CRC1_LD, CRC1_WT, CRC2_LD, CRC2_WT, EOP_REQ, EOP_WT, DONE, ERR
   } state_t;

   state_t      state, state_next;
   pidType      pid_q;
   logic [6:0]  count_q;
   logic [15:0] crc_q, crc_next;
   logic [7:0]  data_q;

   logic        req_data, req_ok, handshake_pkt;
   logic [3:0]  pid_bits;
   logic [15:0] crc_tx;

   assign req_data      = (bus.tx_packet == REQ_DATA0) || (bus.tx_packet == REQ_DATA1);
   assign req_ok        = (bus.tx_packet <= REQ_STALL) &&
                          !(req_data && (int'(bus.buffer_occupancy) > MAX_DATA));
   assign handshake_pkt = pid_q inside {PID_ACK, PID_NAK, PID_STALL};
   assign pid_bits      = pid_q;
   assign crc_tx        = ~crc_q;

   usb_crc16_byte u_crc (
      .crc_in    (crc_q),
      .data_byte (bus.tx_packet_data),
      .crc_out   (crc_next)
   );

`ifdef USB_TX_TIMEOUT_EN
   localparam int WDOG_W = $clog2(TIMEOUT + 1);

   logic [WDOG_W-1:0] wdog;
   logic              in_wait, timeout_hit;

   assign in_wait     = state inside {SYNC_WT, PID_WT, DATA_WT, CRC1_WT, CRC2_WT, EOP_WT};
   assign timeout_hit = in_wait && (wdog == WDOG_W'(TIMEOUT - 1));

   // Any state change restarts the count, so each wait gets the full budget.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)                   wdog <= '0;
      else if (state_next != state) wdog <= '0;
      else if (in_wait)             wdog <= wdog + WDOG_W'(1);
   end
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state   <= IDLE;
         pid_q   <= PID_NONE;
         count_q <= '0;
         crc_q   <= '0;
         data_q  <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && bus.tx_packet != REQ_NONE) begin
            pid_q   <= req_to_pid(bus.tx_packet);
            count_q <= req_data ? bus.buffer_occupancy : '0;
         end
         if (state == PID_LD) crc_q <= CRC16_SEED;
         if (state == DATA_LD) begin
            crc_q   <= crc_next;
            count_q <= count_q - 7'd1;
            data_q  <= bus.tx_packet_data;
         end
      end
   end

   always_comb begin
      state_next             = state;
      bus.get_tx_packet_data = 1'b0;
      bus.load_byte          = 1'b0;
      bus.tx_byte            = 8'h00;
      bus.send_eop           = 1'b0;
      bus.tx_done            = 1'b0;
      bus.tx_error           = 1'b0;
      bus.flush              = 1'b0;
      bus.tx_transfer_active = !(state inside {IDLE, DONE, ERR});

      case (state)
         IDLE: begin
            if (bus.tx_packet != REQ_NONE) state_next = req_ok ? SYNC_LD : ERR;
         end
         SYNC_LD: begin
            bus.load_byte = 1'b1;
            bus.tx_byte   = SYNC_BYTE;
            state_next    = SYNC_WT;
         end
         SYNC_WT: begin
            bus.tx_byte = SYNC_BYTE;
            if (bus.byte_sent) state_next = PID_LD;
         end
         PID_LD: begin
            bus.load_byte = 1'b1;
            bus.tx_byte   = {~pid_bits, pid_bits};
            state_next    = PID_WT;
         end
         PID_WT: begin
            bus.tx_byte = {~pid_bits, pid_bits};
            if (bus.byte_sent) begin
               if (handshake_pkt)       state_next = EOP_REQ;
               else if (count_q != '0)  state_next = DATA_LD;
               else                     state_next = CRC1_LD;
            end
         end
         DATA_LD: begin
            bus.get_tx_packet_data = 1'b1;
            bus.load_byte          = 1'b1;
            bus.tx_byte            = bus.tx_packet_data;
            state_next             = DATA_WT;
         end
         DATA_WT: begin
            bus.tx_byte = data_q;
            if (bus.byte_sent) state_next = (count_q != '0) ? DATA_LD : CRC1_LD;
         end
         CRC1_LD: begin
            bus.load_byte = 1'b1;
            bus.tx_byte   = crc_tx[7:0];
            state_next    = CRC1_WT;
         end
         CRC1_WT: begin
            bus.tx_byte = crc_tx[7:0];
            if (bus.byte_sent) state_next = CRC2_LD;
         end
         CRC2_LD: begin
            bus.load_byte = 1'b1;
            bus.tx_byte   = crc_tx[15:8];
            state_next    = CRC2_WT;
         end
         CRC2_WT: begin
            bus.tx_byte = crc_tx[15:8];
            if (bus.byte_sent) state_next = EOP_REQ;
         end
         EOP_REQ: begin
            bus.send_eop = 1'b1;
            state_next   = EOP_WT;
         end
         EOP_WT: begin
            if (bus.eop_done) state_next = DONE;
         end
         DONE: begin
            bus.tx_done = 1'b1;
            state_next  = IDLE;
         end
         ERR: begin
            bus.tx_error = 1'b1;
            bus.flush    = 1'b1;
            state_next   = IDLE;
         end
         default: state_next = IDLE;
      endcase

`ifdef USB_TX_TIMEOUT_EN
      if (timeout_hit && state_next == state) state_next = ERR;
`endif
   end

endmodule

// File: tb/tb_usb_tx_pcu.sv
// Scoreboard bench for usb_tx_pcu: expected serializer bytes are queued per
// request and popped as load_byte strobes appear; a serializer model answers.
module tb_usb_tx_pcu;
   import usb_pkg::*;

   logic clk = 1'b0;
   logic n_rst;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] fifo_q[$];

   usb_tx_pcu_if bus ();

`ifdef USB_TX_TIMEOUT_EN
   usb_tx_pcu #(.TIMEOUT(20)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));
`else
   usb_tx_pcu dut (.clk(clk), .n_rst(n_rst), .bus(bus));
`endif

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
      $fatal(1);
   end

   function automatic logic [14:0] outs();
      return {bus.get_tx_packet_data, bus.load_byte, bus.tx_byte, bus.send_eop,
              bus.tx_transfer_active, bus.tx_done, bus.tx_error, bus.flush};
   endfunction

   function automatic logic [7:0] rev8(input logic [7:0] x);
      logic [7:0] r;
      for (int k = 0; k < 8; k++) r[k] = x[7-k];
      return r;
   endfunction

   // Shift-register form of the USB CRC16, bits fed in line order.
   function automatic logic [15:0] crc_model(input logic [7:0] d[$]);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      foreach (d[i]) begin
         for (int b = 0; b < 8; b++) begin
            fb = d[i][b] ^ c[15];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h8005;
         end
      end
      return c;
   endfunction

   task automatic drive_fifo();
      bus.buffer_occupancy = 7'(fifo_q.size());
      bus.tx_packet_data   = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
   endtask

   task automatic prep_data(input logic [7:0] pid_byte);
      logic [15:0] c;
      c = ~crc_model(fifo_q);
      exp_q.push_back(8'h80);
      exp_q.push_back(pid_byte);
      foreach (fifo_q[i]) exp_q.push_back(fifo_q[i]);
      exp_q.push_back(rev8(c[15:8]));
      exp_q.push_back(rev8(c[7:0]));
      drive_fifo();
   endtask

   task automatic request(input logic [2:0] code);
      @(negedge clk);
      bus.tx_packet = code;
   endtask

   // Serializer + FIFO model; compares every loaded byte against the scoreboard.
   task automatic serve(input int budget, input logic [2:0] hold_code, input bit stop_at_pop,
                        output int n_loads, output int n_pops, output int n_eops,
                        output bit got_done, output bit got_err);
      int         bs_cnt, eop_cnt;
      bit         pop_pend;
      logic [7:0] last, e;
      bs_cnt = -1; eop_cnt = -1; pop_pend = 0; last = 8'h00;
      n_loads = 0; n_pops = 0; n_eops = 0; got_done = 0; got_err = 0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         bus.tx_packet = hold_code;
         bus.byte_sent = 1'b0;
         bus.eop_done  = 1'b0;
         if (pop_pend) begin
            if (fifo_q.size() > 0) fifo_q.delete(0);
            drive_fifo();
            pop_pend = 0;
         end
         if (bus.tx_error) begin
            got_err = 1;
            checks++;
            if (bus.flush !== 1'b1) begin
               errors++;
               $display("FAIL flush_with_error: got %b, expected 1", bus.flush);
            end
            break;
         end
         if (bus.tx_done) begin
            got_done = 1;
            break;
         end
         if (bus.load_byte) begin
            n_loads++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL byte_unexpected: got %h, expected no load", bus.tx_byte);
            end else begin
               e = exp_q.pop_front();
               if (bus.tx_byte !== e) begin
                  errors++;
                  $display("FAIL tx_byte[%0d]: got %h, expected %h", n_loads - 1, bus.tx_byte, e);
               end
            end
            last   = bus.tx_byte;
            bs_cnt = 8;
         end else if (bs_cnt > 0) begin
            checks++;
            if (bus.tx_byte !== last) begin
               errors++;
               $display("FAIL tx_byte_hold: got %h, expected %h", bus.tx_byte, last);
            end
         end
         if (bus.get_tx_packet_data) begin
            n_pops++;
            pop_pend = 1;
            if (stop_at_pop) break;
         end
         if (bus.send_eop) begin
            n_eops++;
            eop_cnt = 3;
         end
         if (bs_cnt > 0) begin
            bs_cnt--;
            if (bs_cnt == 0) begin bus.byte_sent = 1'b1; bs_cnt = -1; end
         end
         if (eop_cnt > 0) begin
            eop_cnt--;
            if (eop_cnt == 0) begin bus.eop_done = 1'b1; eop_cnt = -1; end
         end
      end
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (outs() !== 15'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h, expected 0000", outs());
      end
      n_rst = 1'b1;
      @(negedge clk);
      checks++;
      if (outs() !== 15'h0) begin
         errors++;
         $display("FAIL idle_outputs: got %h, expected 0000", outs());
      end
   endtask

   task automatic test_spurious();
      bus.byte_sent = 1'b1;
      bus.eop_done  = 1'b1;
      @(negedge clk);
      bus.byte_sent = 1'b0;
      bus.eop_done  = 1'b0;
      @(negedge clk);
      checks++;
      if (outs() !== 15'h0) begin
         errors++;
         $display("FAIL spurious_idle: got %h, expected 0000", outs());
      end
   endtask

   task automatic finish_check(input string name, input bit got_done, input int n_loads,
                               input int n_pops, input int n_eops,
                               input int exp_loads, input int exp_pops);
      checks++;
      if (got_done !== 1'b1 || n_eops != 1) begin
         errors++;
         $display("FAIL %s_done: done=%b eops=%0d, expected done=1 eops=1", name, got_done, n_eops);
      end
      checks++;
      if (n_loads != exp_loads || n_pops != exp_pops || exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_counts: loads=%0d pops=%0d left=%0d, expected loads=%0d pops=%0d left=0",
                  name, n_loads, n_pops, exp_q.size(), exp_loads, exp_pops);
      end
      checks++;
      if (bus.tx_transfer_active !== 1'b0) begin
         errors++;
         $display("FAIL %s_active_at_done: got %b, expected 0", name, bus.tx_transfer_active);
      end
      bus.tx_packet = REQ_NONE;
      @(negedge clk);
      checks++;
      if (outs() !== 15'h0) begin
         errors++;
         $display("FAIL %s_back_idle: got %h, expected 0000", name, outs());
      end
   endtask

   task automatic test_handshakes();
      int nl, np, ne; bit d, er;
      logic [2:0] codes [3];
      logic [7:0] pids  [3];
      codes = '{REQ_ACK, REQ_NAK, REQ_STALL};
      pids  = '{8'hD2, 8'h5A, 8'h1E};
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(8'h80);
         exp_q.push_back(pids[k]);
         request(codes[k]);
         serve(200, REQ_NONE, 0, nl, np, ne, d, er);
         finish_check("handshake", d, nl, np, ne, 2, 0);
      end
   endtask

   task automatic test_data0();
      int nl, np, ne; bit d, er;
      fifo_q = '{8'h00, 8'h01};
      prep_data(8'hC3);
      request(REQ_DATA0);
      serve(300, REQ_NONE, 0, nl, np, ne, d, er);
      finish_check("data0", d, nl, np, ne, 6, 2);
   endtask

   task automatic test_zlp();
      int nl, np, ne; bit d, er;
      fifo_q.delete();
      exp_q = '{8'h80, 8'h4B, 8'h00, 8'h00};
      drive_fifo();
      request(REQ_DATA1);
      serve(300, REQ_NONE, 0, nl, np, ne, d, er);
      finish_check("zlp", d, nl, np, ne, 4, 0);
   endtask

   // Full 64-byte packet with the request left asserted throughout.
   task automatic test_back_to_back();
      int nl, np, ne; bit d, er;
      fifo_q.delete();
      for (int i = 0; i < 64; i++) fifo_q.push_back(8'($urandom_range(0, 255)));
      prep_data(8'h4B);
      request(REQ_DATA1);
      serve(2000, REQ_ACK, 0, nl, np, ne, d, er);
      finish_check("max_data", d, nl, np, ne, 68, 64);
   endtask

   task automatic test_errors();
      int nl, np, ne; bit d, er;
      logic [2:0] codes [3];
      codes = '{3'd7, 3'd6, REQ_DATA0};
      for (int k = 0; k < 3; k++) begin
         fifo_q.delete();
         drive_fifo();
         if (k == 2) bus.buffer_occupancy = 7'd65;
         request(codes[k]);
         serve(20, REQ_NONE, 0, nl, np, ne, d, er);
         checks++;
         if (er !== 1'b1 || nl != 0 || np != 0) begin
            errors++;
            $display("FAIL error_req%0d: err=%b loads=%0d pops=%0d, expected err=1 loads=0 pops=0",
                     k, er, nl, np);
         end
         checks++;
         if (bus.tx_transfer_active !== 1'b0) begin
            errors++;
            $display("FAIL error_active: got %b, expected 0", bus.tx_transfer_active);
         end
         @(negedge clk);
         checks++;
         if (outs() !== 15'h0) begin
            errors++;
            $display("FAIL error_single_cycle: got %h, expected 0000", outs());
         end
      end
      drive_fifo();
   endtask

   task automatic test_reset_mid();
      int nl, np, ne; bit d, er;
      fifo_q = '{8'hAA, 8'hBB, 8'hCC};
      prep_data(8'hC3);
      request(REQ_DATA0);
      serve(300, REQ_NONE, 1, nl, np, ne, d, er);
      checks++;
      if (np != 1) begin
         errors++;
         $display("FAIL mid_reached_data: pops=%0d, expected 1", np);
      end
      @(posedge clk);
      #2;
      n_rst = 1'b0;
      #1;
      checks++;
      if (outs() !== 15'h0) begin
         errors++;
         $display("FAIL async_reset_outputs: got %h, expected 0000", outs());
      end
      @(negedge clk);
      n_rst = 1'b1;
      exp_q.delete();
      fifo_q.delete();
      drive_fifo();
      exp_q = '{8'h80, 8'hD2};
      request(REQ_ACK);
      serve(200, REQ_NONE, 0, nl, np, ne, d, er);
      finish_check("after_reset", d, nl, np, ne, 2, 0);
   endtask

`ifdef USB_TX_TIMEOUT_EN
   task automatic test_timeout();
      int  waits;
      bit  seen;
      request(REQ_ACK);
      @(negedge clk);
      bus.tx_packet = REQ_NONE;
      checks++;
      if (bus.load_byte !== 1'b1 || bus.tx_byte !== 8'h80) begin
         errors++;
         $display("FAIL timeout_sync: load=%b byte=%h, expected load=1 byte=80", bus.load_byte, bus.tx_byte);
      end
      waits = 0; seen = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (bus.tx_error) begin seen = 1; break; end
         waits++;
      end
      checks++;
      if (seen !== 1'b1 || waits != 20) begin
         errors++;
         $display("FAIL timeout_fire: seen=%b waits=%0d, expected seen=1 waits=20", seen, waits);
      end
      checks++;
      if (bus.flush !== 1'b1 || bus.tx_transfer_active !== 1'b0) begin
         errors++;
         $display("FAIL timeout_flags: flush=%b active=%b, expected flush=1 active=0",
                  bus.flush, bus.tx_transfer_active);
      end
      @(negedge clk);
      checks++;
      if (outs() !== 15'h0) begin
         errors++;
         $display("FAIL timeout_idle: got %h, expected 0000", outs());
      end
   endtask
`endif

   initial begin
      bus.tx_packet = REQ_NONE;
      bus.byte_sent = 1'b0;
      bus.eop_done  = 1'b0;
      fifo_q.delete();
      drive_fifo();
      test_reset();
      test_spurious();
      test_handshakes();
      test_data0();
      test_zlp();
      test_back_to_back();
      test_errors();
      test_reset_mid();
`ifdef USB_TX_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
